// File: rtl/multi_button_debouncer.sv
// N-channel push-button front end: synchroniser, stability-count debouncer,
// registered rise/fall pulses and a per-channel long-press / auto-repeat FSM.
module multi_button_debouncer #(
   parameter int NUM_BTN     = 4,
   parameter int SYNC_STAGES = 2,
   parameter int STABLE_CNT  = 8,
   parameter int LONG_CNT    = 400,
   parameter int REPEAT_CNT  = 100,
   parameter int ACTIVE_LOW  = 0
) (
   input  logic               sampling_clk,
   input  logic               rst,
   input  logic [NUM_BTN-1:0] btn,
   output logic [NUM_BTN-1:0] level,
   output logic [NUM_BTN-1:0] rise,
   output logic [NUM_BTN-1:0] fall,
   output logic [NUM_BTN-1:0] long_press,
   output logic [NUM_BTN-1:0] repeat_pulse
);

   localparam int STABLE_W = $clog2(STABLE_CNT + 1);
   localparam int HOLD_MAX = (LONG_CNT > REPEAT_CNT) ? LONG_CNT : REPEAT_CNT;
   localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESSED = 2'd1,
      HELD    = 2'd2
   } hold_state_e;

   // Everything downstream of this point treats 1 as "pressed".
   logic [NUM_BTN-1:0] btn_pol;
   assign btn_pol = (ACTIVE_LOW != 0) ? ~btn : btn;

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q;
      logic                   s;
      logic [STABLE_W-1:0]    stab_q, stab_d;
      logic                   level_q, level_d;
      logic                   rise_q, rise_d;
      logic                   fall_q, fall_d;
      hold_state_e            state_q, state_d;
      logic [HOLD_W-1:0]      hold_q, hold_d;
      logic                   long_q, long_d;
      logic                   rep_q, rep_d;

      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value of its neighbours.
      always_ff @(posedge sampling_clk or posedge rst) begin
         if (rst) begin
            sync_q <= '0;
         end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_pol[i]};
         end
      end

      assign s = sync_q[SYNC_STAGES-1];

      // NOTE: every always_comb output gets a default first so no latch is inferred.
      always_comb begin
         stab_d  = stab_q;
         level_d = level_q;
         rise_d  = 1'b0;
         fall_d  = 1'b0;
         if (s == level_q) begin
            stab_d = '0;
         end else if (stab_q == STABLE_W'(STABLE_CNT - 1)) begin
            stab_d  = '0;
            level_d = s;
            rise_d  = s;
            fall_d  = ~s;
         end else begin
            stab_d = stab_q + 1'b1;
         end
      end

      always_ff @(posedge sampling_clk or posedge rst) begin
         if (rst) begin
            stab_q  <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
         end else begin
            stab_q  <= stab_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
         end
      end

      // The hold FSM reacts to the same-edge debounce events (rise_d/fall_d),
      // so its count starts on the edge that raises level.
      always_comb begin
         state_d = state_q;
         hold_d  = hold_q;
         long_d  = 1'b0;
         rep_d   = 1'b0;
         unique case (state_q)
            IDLE: begin
               if (rise_d) begin
                  state_d = PRESSED;
                  hold_d  = '0;
               end
            end
            PRESSED: begin
               if (fall_d) begin
                  state_d = IDLE;
                  hold_d  = '0;
               end else if (hold_q == HOLD_W'(LONG_CNT - 1)) begin
                  long_d  = 1'b1;
                  state_d = HELD;
                  hold_d  = '0;
               end else begin
                  hold_d = hold_q + 1'b1;
               end
            end
            HELD: begin
               if (fall_d) begin
                  state_d = IDLE;
                  hold_d  = '0;
               end else if (REPEAT_CNT > 0) begin
                  if (hold_q == HOLD_W'(REPEAT_CNT - 1)) begin
                     rep_d  = 1'b1;
                     hold_d = '0;
                  end else begin
                     hold_d = hold_q + 1'b1;
                  end
               end
            end
            default: begin
               state_d = IDLE;
               hold_d  = '0;
            end
         endcase
      end

      always_ff @(posedge sampling_clk or posedge rst) begin
         if (rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
            long_q  <= 1'b0;
            rep_q   <= 1'b0;
         end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            long_q  <= long_d;
            rep_q   <= rep_d;
         end
      end

      assign level[i]        = level_q;
      assign rise[i]         = rise_q;
      assign fall[i]         = fall_q;
      assign long_press[i]   = long_q;
      assign repeat_pulse[i] = rep_q;
   end

endmodule

// File: tb/tb_multi_button_debouncer.sv
// Bench for multi_button_debouncer: three configurations driven in lock-step
// and compared every cycle against a history-based reference model.
module tb_multi_button_debouncer;

   localparam int NB     = 4;
   localparam int NI     = 3;
   localparam int SYNC   = 2;
   localparam int STABLE = 4;
   localparam int LONG   = 20;
   localparam int HN     = 4096;

   // Instance 0: common setup; 1: REPEAT_CNT=0; 2: ACTIVE_LOW=1.
   int cfg_rep [NI] = '{5, 0, 5};
   int cfg_al  [NI] = '{0, 0, 1};

   logic clk = 1'b0;
   logic rst;
   logic [NB-1:0] btn_d  [NI];
   logic [NB-1:0] lvl_o  [NI];
   logic [NB-1:0] rise_o [NI];
   logic [NB-1:0] fall_o [NI];
   logic [NB-1:0] long_o [NI];
   logic [NB-1:0] rep_o  [NI];

   always #5 clk = ~clk;

   multi_button_debouncer #(.NUM_BTN(NB), .SYNC_STAGES(SYNC), .STABLE_CNT(STABLE),
      .LONG_CNT(LONG), .REPEAT_CNT(5), .ACTIVE_LOW(0)) dut_a (
      .sampling_clk(clk), .rst(rst), .btn(btn_d[0]), .level(lvl_o[0]), .rise(rise_o[0]),
      .fall(fall_o[0]), .long_press(long_o[0]), .repeat_pulse(rep_o[0]));

   multi_button_debouncer #(.NUM_BTN(NB), .SYNC_STAGES(SYNC), .STABLE_CNT(STABLE),
      .LONG_CNT(LONG), .REPEAT_CNT(0), .ACTIVE_LOW(0)) dut_b (
      .sampling_clk(clk), .rst(rst), .btn(btn_d[1]), .level(lvl_o[1]), .rise(rise_o[1]),
      .fall(fall_o[1]), .long_press(long_o[1]), .repeat_pulse(rep_o[1]));

   multi_button_debouncer #(.NUM_BTN(NB), .SYNC_STAGES(SYNC), .STABLE_CNT(STABLE),
      .LONG_CNT(LONG), .REPEAT_CNT(5), .ACTIVE_LOW(1)) dut_c (
      .sampling_clk(clk), .rst(rst), .btn(btn_d[2]), .level(lvl_o[2]), .rise(rise_o[2]),
      .fall(fall_o[2]), .long_press(long_o[2]), .repeat_pulse(rep_o[2]));

   int checks = 0;
   int errors = 0;

   // Reference model: per-edge log of pressed samples since reset.
   int n_m;
   bit hist      [NI][NB][HN];
   bit lvl_m     [NI][NB];
   int last_flip [NI][NB];
   int rise_t    [NI][NB];
   logic [NB-1:0] e_lvl [NI], e_rise [NI], e_fall [NI], e_long [NI], e_rep [NI];

   int cnt_rise [NI][NB], cnt_fall [NI][NB], cnt_long [NI][NB], cnt_rep [NI][NB];
   int dur      [NI][NB];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      n_m = 0;
      for (int k = 0; k < NI; k++) begin
         e_lvl[k] = '0; e_rise[k] = '0; e_fall[k] = '0; e_long[k] = '0; e_rep[k] = '0;
         for (int c = 0; c < NB; c++) begin
            lvl_m[k][c]     = 1'b0;
            last_flip[k][c] = 0;
            rise_t[k][c]    = 0;
         end
      end
   endtask

   // Synchronised sample seen by the debouncer at edge m.
   function automatic bit s_seen(int k, int c, int m);
      if (m - SYNC >= 1) return hist[k][c][m - SYNC];
      return 1'b0;
   endfunction

   task automatic model_step();
      bit flip;
      int since;
      if (rst) begin
         model_reset();
         return;
      end
      n_m++;
      if (n_m >= HN) begin
         $display("FAIL model_history observed=%0d expected<%0d", n_m, HN);
         $fatal(1);
      end
      for (int k = 0; k < NI; k++) begin
         for (int c = 0; c < NB; c++) begin
            hist[k][c][n_m] = btn_d[k][c] ^ (cfg_al[k] != 0);
            // Level flips once STABLE consecutive samples since the last flip disagree with it.
            flip = 1'b0;
            if (n_m - STABLE + 1 > last_flip[k][c]) begin
               flip = 1'b1;
               for (int j = 0; j < STABLE; j++)
                  if (s_seen(k, c, n_m - j) == lvl_m[k][c]) flip = 1'b0;
            end
            e_rise[k][c] = 1'b0;
            e_fall[k][c] = 1'b0;
            if (flip) begin
               lvl_m[k][c]     = ~lvl_m[k][c];
               last_flip[k][c] = n_m;
               if (lvl_m[k][c]) begin
                  rise_t[k][c] = n_m;
                  e_rise[k][c] = 1'b1;
               end else begin
                  e_fall[k][c] = 1'b1;
               end
            end
            since = n_m - rise_t[k][c] - LONG;
            e_lvl[k][c]  = lvl_m[k][c];
            e_long[k][c] = lvl_m[k][c] && (since == 0);
            e_rep[k][c]  = lvl_m[k][c] && (cfg_rep[k] > 0) && (since > 0)
                           && (since % ((cfg_rep[k] > 0) ? cfg_rep[k] : 1) == 0);
         end
      end
   endtask

   task automatic compare_all();
      for (int k = 0; k < NI; k++) begin
         check($sformatf("level_i%0d", k),  32'(lvl_o[k]),  32'(e_lvl[k]));
         check($sformatf("rise_i%0d", k),   32'(rise_o[k]), 32'(e_rise[k]));
         check($sformatf("fall_i%0d", k),   32'(fall_o[k]), 32'(e_fall[k]));
         check($sformatf("long_i%0d", k),   32'(long_o[k]), 32'(e_long[k]));
         check($sformatf("repeat_i%0d", k), 32'(rep_o[k]),  32'(e_rep[k]));
      end
   endtask

   task automatic clr_cnt();
      for (int k = 0; k < NI; k++)
         for (int c = 0; c < NB; c++) begin
            cnt_rise[k][c] = 0; cnt_fall[k][c] = 0; cnt_long[k][c] = 0; cnt_rep[k][c] = 0;
         end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
      for (int k = 0; k < NI; k++)
         for (int c = 0; c < NB; c++) begin
            cnt_rise[k][c] += int'(rise_o[k][c]);
            cnt_fall[k][c] += int'(fall_o[k][c]);
            cnt_long[k][c] += int'(long_o[k][c]);
            cnt_rep[k][c]  += int'(rep_o[k][c]);
         end
   endtask

   task automatic idle_all();
      btn_d[0] = '0;
      btn_d[1] = '0;
      btn_d[2] = '1;
   endtask

   int bounce [4] = '{3, 1, 2, 1};

   initial begin
      rst = 1'b1;
      idle_all();
      model_reset();
      clr_cnt();
      repeat (3) tick();
      rst = 1'b0;

      // Idle after reset: active-low instance held at all-ones must stay quiet.
      repeat (10) tick();
      check("al_idle_rise_cnt", 32'(cnt_rise[2][0] + cnt_rise[2][1] + cnt_rise[2][2] + cnt_rise[2][3]), 0);
      check("al_idle_level", 32'(lvl_o[2]), 0);

      // Clean press: btn sampled at edge 1, rise after edge 6, one cycle wide.
      btn_d[0][0] = 1'b1;
      btn_d[2][0] = 1'b0;
      repeat (5) tick();
      check("press_rise_edge5", 32'(rise_o[0][0]), 0);
      tick();
      check("press_rise_edge6", 32'(rise_o[0][0]), 1);
      check("press_level_edge6", 32'(lvl_o[0]), 32'h1);
      check("al_press_rise_edge6", 32'(rise_o[2][0]), 1);
      tick();
      check("press_rise_edge7", 32'(rise_o[0][0]), 0);
      idle_all();
      repeat (10) tick();

      // Bounce on channel 1: no debounced change until a steady high.
      clr_cnt();
      for (int r = 0; r < 3; r++)
         for (int p = 0; p < 4; p++) begin
            btn_d[0][1] = (p % 2 == 0);
            repeat (bounce[p]) tick();
         end
      check("bounce_rise_cnt", 32'(cnt_rise[0][1]), 0);
      check("bounce_level", 32'(lvl_o[0][1]), 0);
      btn_d[0][1] = 1'b1;
      repeat (5) tick();
      check("bounce_final_edge5", 32'(rise_o[0][1]), 0);
      tick();
      check("bounce_final_rise", 32'(rise_o[0][1]), 1);
      idle_all();
      repeat (10) tick();

      // Randomised presses, glitches and holds on every channel of every instance.
      for (int k = 0; k < NI; k++)
         for (int c = 0; c < NB; c++) dur[k][c] = 1;
      for (int t = 0; t < 400; t++) begin
         for (int k = 0; k < NI; k++)
            for (int c = 0; c < NB; c++) begin
               dur[k][c]--;
               if (dur[k][c] <= 0) begin
                  btn_d[k][c] = ~btn_d[k][c];
                  dur[k][c] = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 6))
                                                           : int'($urandom_range(7, 60));
               end
            end
         tick();
      end
      idle_all();
      repeat (20) tick();

      // Long hold on channel 2: long_press at R+20, repeats R+25..R+55.
      clr_cnt();
      btn_d[0][2] = 1'b1;
      btn_d[1][2] = 1'b1;
      repeat (6) tick();
      check("hold_rise", 32'(rise_o[0][2]), 1);
      repeat (20) tick();
      check("hold_long_a", 32'(long_o[0][2]), 1);
      check("hold_long_b", 32'(long_o[1][2]), 1);
      repeat (31) tick();
      btn_d[0][2] = 1'b0;
      btn_d[1][2] = 1'b0;
      repeat (6) tick();
      check("hold_fall", 32'(fall_o[0][2]), 1);
      repeat (14) tick();
      check("hold_rep_cnt_a", 32'(cnt_rep[0][2]), 7);
      check("hold_long_cnt_a", 32'(cnt_long[0][2]), 1);
      check("norep_long_cnt_b", 32'(cnt_long[1][2]), 1);
      check("norep_rep_cnt_b", 32'(cnt_rep[1][2]), 0);

      // Debounced fall on edge R+20 suppresses long_press.
      clr_cnt();
      btn_d[0][3] = 1'b1;
      repeat (6) tick();
      repeat (14) tick();
      btn_d[0][3] = 1'b0;
      repeat (6) tick();
      check("race_fall", 32'(fall_o[0][3]), 1);
      check("race_long", 32'(long_o[0][3]), 0);
      repeat (10) tick();
      check("race_long_cnt", 32'(cnt_long[0][3]), 0);

      // Reset while HELD with the button still pressed.
      btn_d[0][3] = 1'b1;
      repeat (31) tick();
      check("pre_rst_level", 32'(lvl_o[0][3]), 1);
      clr_cnt();
      rst = 1'b1;
      model_reset();
      #1;
      compare_all();
      check("rst_level_async", 32'(lvl_o[0]), 0);
      repeat (2) tick();
      check("rst_pulse_cnt", 32'(cnt_rise[0][3] + cnt_long[0][3] + cnt_rep[0][3] + cnt_fall[0][3]), 0);
      rst = 1'b0;
      repeat (5) tick();
      check("post_rst_edge5", 32'(rise_o[0][3]), 0);
      tick();
      check("post_rst_rise", 32'(rise_o[0][3]), 1);
      repeat (20) tick();
      check("post_rst_long", 32'(long_o[0][3]), 1);
      idle_all();
      repeat (15) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
